lb_pixel_writer: RTL and testbench

LB_PIXEL_WRITER -- requirements
Module: lb_pixel_writer

---
 rtl/lb_pkg.sv | 14 +
 rtl/lb_pixel_writer.sv | 120 ++++++++++++
 tb/tb_lb_pixel_writer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_pkg.sv
// Shared line-buffer definitions: writer FSM states, pixel width and bank depth.
// The line-buffer reader/mux imports this package as well.
package lb_pkg;

    localparam int PIX_W    = 4;
    localparam int LB_DEPTH = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_WRITE = 2'd2
    } lb_state_e;

endpackage

// File: rtl/lb_pixel_writer.sv
// Sprite-row pixel writer for a double-buffered line buffer: writes opaque pixels
// into the current write bank and optionally erases that bank after each swap.
module lb_pixel_writer
    import lb_pkg::*;
#(
    parameter bit CLEAR_EN = 1'b1,
    parameter int LB_DEPTH = 256
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             line_start,
    input  logic             spr_start,
    input  logic [7:0]       spr_x,
    output logic             spr_ready,
    input  logic             px_valid,
    output logic             px_ready,
    input  logic             px_last,
    input  logic [PIX_W-1:0] px_data,
    output logic             wr_bank,
    output logic [7:0]       buf_addr,
    output logic [PIX_W-1:0] buf_wdata,
    output logic             buf_we_a,
    output logic             buf_we_b,
    output logic             busy
);

    localparam logic [8:0] LAST_X = 9'(LB_DEPTH - 1);

    lb_state_e        state, state_n;
    // Clear address in CLEAR, sprite X in WRITE; bit 8 marks "past the right edge".
    logic [8:0]       cnt, cnt_n;
    logic             bank_n;
    logic [7:0]       addr_n;
    logic [PIX_W-1:0] wdata_n;
    logic             we_a_n, we_b_n;

    assign px_ready  = (state == ST_WRITE);
    assign spr_ready = (state == ST_IDLE) && !line_start;
    assign busy      = (state != ST_IDLE);

    // NOTE: every next-value signal gets a default before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bank_n  = wr_bank;
        addr_n  = buf_addr;
        wdata_n = buf_wdata;
        we_a_n  = 1'b0;
        we_b_n  = 1'b0;

        if (line_start) begin
            bank_n  = ~wr_bank;
            cnt_n   = '0;
            state_n = CLEAR_EN ? ST_CLEAR : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (spr_start) begin
                        cnt_n   = {1'b0, spr_x};
                        state_n = ST_WRITE;
                    end
                end
                ST_CLEAR: begin
                    addr_n  = cnt[7:0];
                    wdata_n = '0;
                    we_a_n  = ~wr_bank;
                    we_b_n  = wr_bank;
                    if (cnt == LAST_X) begin
                        cnt_n   = '0;
                        state_n = ST_IDLE;
                    end else begin
                        cnt_n = cnt + 9'd1;
                    end
                end
                ST_WRITE: begin
                    if (px_valid) begin
                        // Past the last slot the pixel is consumed but never written.
                        if (cnt <= LAST_X) begin
                            cnt_n = cnt + 9'd1;
                            if (px_data != '0) begin
                                addr_n  = cnt[7:0];
                                wdata_n = px_data;
                                we_a_n  = ~wr_bank;
                                we_b_n  = wr_bank;
                            end
                        end
                        if (px_last) begin
                            state_n = ST_IDLE;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // NOTE: the strobes live in an asynchronously reset register, so asserting
    // nReset kills any write in flight without waiting for a clock edge.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            wr_bank   <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            buf_we_a  <= 1'b0;
            buf_we_b  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            wr_bank   <= bank_n;
            buf_addr  <= addr_n;
            buf_wdata <= wdata_n;
            buf_we_a  <= we_a_n;
            buf_we_b  <= we_b_n;
        end
    end

endmodule

// File: tb/tb_lb_pixel_writer.sv
// Bench for lb_pixel_writer: scenario tasks drive stimulus and compare the observed
// write log against a log predicted from the line-buffer rules.
module tb_lb_pixel_writer;
    import lb_pkg::*;

    typedef struct packed {
        logic       bank;
        logic [7:0] addr;
        logic [3:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       nReset;
    logic       line_start, spr_start, px_valid, px_last;
    logic [7:0] spr_x;
    logic [3:0] px_data;
    logic       spr_ready, px_ready, wr_bank, buf_we_a, buf_we_b, busy;
    logic [7:0] buf_addr;
    logic [3:0] buf_wdata;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   bank_viol = 0;
    logic exp_bank;

    wr_t        obs_q[$];
    int         obs_cyc[$];
    wr_t        exp_q[$];
    logic [3:0] row_q[$];

    lb_pixel_writer #(.CLEAR_EN(1'b1), .LB_DEPTH(256)) dut (
        .clk(clk), .nReset(nReset), .line_start(line_start), .spr_start(spr_start),
        .spr_x(spr_x), .spr_ready(spr_ready), .px_valid(px_valid), .px_ready(px_ready),
        .px_last(px_last), .px_data(px_data), .wr_bank(wr_bank), .buf_addr(buf_addr),
        .buf_wdata(buf_wdata), .buf_we_a(buf_we_a), .buf_we_b(buf_we_b), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (buf_we_a || buf_we_b) begin
            if ((buf_we_a && buf_we_b) || (buf_we_b !== wr_bank)) bank_viol++;
            obs_q.push_back(wr_t'{buf_we_b, buf_addr, buf_wdata});
            obs_cyc.push_back(cyc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs;
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    function automatic void expect_clear(input logic bank);
        for (int a = 0; a < 256; a++) exp_q.push_back(wr_t'{bank, 8'(a), 4'd0});
    endfunction

    // Reference model of a sprite row: pixel i lands at x+i, unless it is
    // transparent or falls beyond the last slot of the bank.
    function automatic void expect_row(input logic bank, input int x);
        for (int i = 0; i < row_q.size(); i++) begin
            if (x + i < LB_DEPTH && row_q[i] != 4'd0)
                exp_q.push_back(wr_t'{bank, 8'(x + i), row_q[i]});
        end
    endfunction

    function automatic int log_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic report_diff(input string name, input int d);
        wr_t o, e;
        o = (d < obs_q.size()) ? obs_q[d] : '0;
        e = (d < exp_q.size()) ? exp_q[d] : '0;
        $display("FAIL %s: entry %0d observed bank%0d addr=%0d data=%0d (%0d writes), expected bank%0d addr=%0d data=%0d (%0d writes)",
                 name, d, o.bank, o.addr, o.data, obs_q.size(), e.bank, e.addr, e.data, exp_q.size());
    endtask

    // Sprite row from row_q starting at x; optional random px_valid gaps.
    task automatic drive_row(input logic [7:0] x, input bit gaps);
        spr_start = 1'b1;
        spr_x     = x;
        tick();
        spr_start = 1'b0;
        for (int i = 0; i < row_q.size(); i++) begin
            if (gaps) begin
                px_valid = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end
            px_valid = 1'b1;
            px_data  = row_q[i];
            px_last  = (i == row_q.size() - 1);
            tick();
        end
        px_valid = 1'b0;
        px_last  = 1'b0;
        tick();
        expect_row(exp_bank, int'(x));
    endtask

    task automatic wait_idle(output bit ok);
        for (int k = 0; k < 400 && busy; k++) tick();
        ok = !busy;
    endtask

    task automatic test_reset;
        nReset = 1'b0; line_start = 1'b0; spr_start = 1'b0; spr_x = '0;
        px_valid = 1'b0; px_last = 1'b0; px_data = '0;
        exp_bank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (wr_bank !== 1'b0) begin n_fail++; $display("FAIL reset_wr_bank: got %b want 0", wr_bank); end
        n_checks++; if ({buf_addr, buf_wdata} !== 12'h0) begin n_fail++; $display("FAIL reset_addr_data: got addr=%0h data=%0h want 0/0", buf_addr, buf_wdata); end
        n_checks++; if ({buf_we_a, buf_we_b} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %b want 00", {buf_we_a, buf_we_b}); end
        n_checks++; if ({busy, px_ready, spr_ready} !== 3'b001) begin n_fail++; $display("FAIL reset_status: busy/px_ready/spr_ready got %b want 001", {busy, px_ready, spr_ready}); end
        #3 nReset = 1'b1;
        tick();
    endtask

    task automatic test_clear;
        bit ok;
        int start, bad;
        clear_logs();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        start    = cyc;
        exp_bank = ~exp_bank;
        n_checks++; if (wr_bank !== exp_bank) begin n_fail++; $display("FAIL clear_bank_toggle: got %b want %b", wr_bank, exp_bank); end
        n_checks++; if ({busy, spr_ready} !== 2'b10) begin n_fail++; $display("FAIL clear_busy: busy/spr_ready got %b want 10", {busy, spr_ready}); end
        expect_clear(exp_bank);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL clear_timeout: busy still %b after 400 cycles, want 0", busy); end
        tick();
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("clear_log", d); end end
        bad = 0;
        foreach (obs_cyc[i]) if (obs_cyc[i] != start + 1 + i) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL clear_consecutive: %0d strobes off the expected cycle, want 0", bad); end
    endtask

    task automatic test_transparency;
        clear_logs();
        row_q = '{4'd3, 4'd0, 4'd7};
        drive_row(8'd10, 1'b0);
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("transparent_log", d); end end
        n_checks++; if ({busy, spr_ready} !== 2'b01) begin n_fail++; $display("FAIL transparent_idle: busy/spr_ready got %b want 01", {busy, spr_ready}); end
    endtask

    task automatic test_right_edge;
        clear_logs();
        row_q = '{4'd5, 4'd5, 4'd5, 4'd5};
        drive_row(8'd254, 1'b0);
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("edge_log", d); end end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL edge_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_random_rows;
        int v0;
        clear_logs();
        v0 = bank_viol;
        for (int r = 0; r < 25; r++) begin
            row_q.delete();
            repeat ($urandom_range(1, 12)) row_q.push_back(4'($urandom_range(0, 15)));
            drive_row(($urandom_range(0, 3) == 0) ? 8'($urandom_range(245, 255)) : 8'($urandom_range(0, 255)), 1'b1);
        end
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("random_log", d); end end
        n_checks++; if (bank_viol != v0) begin n_fail++; $display("FAIL random_bank: %0d strobes on wrong/both banks, want 0", bank_viol - v0); end
    endtask

    task automatic test_back_to_back;
        clear_logs();
        row_q = '{4'd1, 4'd2, 4'd3};
        drive_row(8'd100, 1'b0);
        row_q = '{4'd4, 4'd0, 4'd6, 4'd8};
        drive_row(8'd103, 1'b0);
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("b2b_log", d); end end
    endtask

    task automatic test_line_start_abort;
        bit ok;
        int start;
        clear_logs();
        row_q = '{4'd9, 4'd8};
        expect_row(exp_bank, 40);
        spr_start = 1'b1;
        spr_x     = 8'd40;
        tick();
        spr_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            px_valid = 1'b1;
            px_data  = 4'(9 - i);
            tick();
        end
        px_data    = 4'd7;
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        px_valid   = 1'b0;
        start      = cyc;
        exp_bank   = ~exp_bank;
        n_checks++; if (wr_bank !== exp_bank) begin n_fail++; $display("FAIL abort_bank: got %b want %b", wr_bank, exp_bank); end
        n_checks++; if ({busy, px_ready} !== 2'b10) begin n_fail++; $display("FAIL abort_clear_state: busy/px_ready got %b want 10", {busy, px_ready}); end
        expect_clear(exp_bank);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_timeout: busy still %b, want 0", busy); end
        tick();
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("abort_log", d); end end
        n_checks++; if (obs_cyc.size() < 3 || obs_cyc[2] != start + 1) begin n_fail++; $display("FAIL abort_clear_start: first clear strobe cycle %0d want %0d", (obs_cyc.size() > 2) ? obs_cyc[2] : -1, start + 1); end
    endtask

    task automatic test_collision;
        bit ok;
        clear_logs();
        spr_start  = 1'b1;
        spr_x      = 8'd5;
        line_start = 1'b1;
        #1;
        n_checks++; if (spr_ready !== 1'b0) begin n_fail++; $display("FAIL collide_ready: spr_ready got %b want 0", spr_ready); end
        tick();
        spr_start  = 1'b0;
        line_start = 1'b0;
        exp_bank   = ~exp_bank;
        n_checks++; if ({wr_bank, busy, px_ready} !== {exp_bank, 2'b10}) begin n_fail++; $display("FAIL collide_state: wr_bank/busy/px_ready got %b want %b", {wr_bank, busy, px_ready}, {exp_bank, 2'b10}); end
        repeat (20) tick();
        spr_start = 1'b1;
        spr_x     = 8'd7;
        px_valid  = 1'b1;
        px_data   = 4'd3;
        tick();
        spr_start = 1'b0;
        repeat (3) tick();
        px_valid = 1'b0;
        expect_clear(exp_bank);
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL collide_timeout: busy still %b, want 0", busy); end
        tick();
        n_checks++; if (px_ready !== 1'b0) begin n_fail++; $display("FAIL collide_no_write_state: px_ready got %b want 0", px_ready); end
        n_checks++; begin int d = log_diff(); if (d >= 0) begin n_fail++; report_diff("collide_log", d); end end
    endtask

    task automatic test_reset_mid_clear;
        bit found;
        clear_logs();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if ((buf_we_a || buf_we_b) && buf_addr == 8'd100) found = 1'b1;
            else tick();
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL rstclr_reach: clear never reached addr 100 (addr=%0d)", buf_addr); end
        #2 nReset = 1'b0;
        #1;
        n_checks++; if ({buf_we_a, buf_we_b} !== 2'b00) begin n_fail++; $display("FAIL rstclr_async_strobe: got %b want 00", {buf_we_a, buf_we_b}); end
        n_checks++; if ({wr_bank, busy} !== 2'b00) begin n_fail++; $display("FAIL rstclr_async_state: wr_bank/busy got %b want 00", {wr_bank, busy}); end
        exp_bank = 1'b0;
        #20;
        obs_q.delete();
        obs_cyc.delete();
        nReset = 1'b1;
        repeat (10) tick();
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstclr_no_writes: %0d writes after release, want 0", obs_q.size()); end
        n_checks++; if ({busy, spr_ready, wr_bank} !== 3'b010) begin n_fail++; $display("FAIL rstclr_idle: busy/spr_ready/wr_bank got %b want 010", {busy, spr_ready, wr_bank}); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_transparency();
        test_right_edge();
        test_random_rows();
        test_back_to_back();
        test_line_start_abort();
        test_collision();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
